ps2_key_gen: RTL and testbench

PS2_KEY_GEN -- requirements
Module: ps2_key_gen

---
 rtl/ps2_key_gen_if.sv | 24 ++
 rtl/ps2_key_gen.sv | 181 ++++++++++++++++++
 tb/tb_ps2_key_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_gen_if.sv
// PS/2 key generator bus: raw PS/2 lines in, key event word and status pulses out.
interface ps2_key_gen_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        key_strobe;
    logic        frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output key_strobe,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  key_strobe,
        input  frame_err
    );
endinterface

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, deframes bytes and
// turns scancode sequences into key events. Define PS2_PARITY_CHECK_EN to reject bad parity.
module ps2_key_gen #(
    parameter int CLK_FILTER = 8,
    parameter int TIMEOUT    = 40000
) (
    input  logic          clk_sys,
    input  logic          reset,
    ps2_key_gen_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [3:0]      FILT_LAST = 4'(CLK_FILTER - 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic            data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic            filt_q, filt_d;
    logic [3:0]      filt_cnt_q, filt_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            ext_q, ext_d, rel_q, rel_d;
    logic [2:0]      skip_q, skip_d;
    logic [10:0]     key_q, key_d;
    logic            strobe_q, strobe_d, err_q, err_d;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_ok_q, par_ok_d;
`endif
    logic            bit_event, stop_ok, accept, discard;

    always_comb begin
        clk_s1_d   = bus.ps2_clk;
        clk_s2_d   = clk_s1_q;
        data_s1_d  = bus.ps2_data;
        data_s2_d  = data_s1_q;
        filt_d     = filt_q;
        filt_cnt_d = '0;
        bit_event  = 1'b0;
        // The filtered level flips on the CLK_FILTER-th consecutive differing sample.
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d    = clk_s2_q;
                bit_event = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wdog_d    = '0;
        ext_d     = ext_q;
        rel_d     = rel_q;
        skip_d    = skip_q;
        key_d     = key_q;
        strobe_d  = 1'b0;
        err_d     = 1'b0;
        accept    = 1'b0;
        discard   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_ok_d  = par_ok_q;
        stop_ok   = data_s2_q & par_ok_q;
`else
        stop_ok   = data_s2_q;
`endif

        if (bit_event) begin
            case (state_q)
                IDLE: begin
                    if (!data_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        discard = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_ok_d = ^{data_s2_q, shift_q};
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (stop_ok) accept  = 1'b1;
                    else         discard = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // Timeout drops the partial byte but keeps any pending E0/F0 prefix.
            if (wdog_q == WD_LAST) begin
                state_d = IDLE;
                shift_d = '0;
                err_d   = 1'b1;
            end else begin
                wdog_d = wdog_q + WD_W'(1);
            end
        end

        if (discard) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
        end

        if (accept) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (shift_q == 8'hE1) begin
                skip_d = 3'd7;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                rel_d = 1'b1;
            end else begin
                key_d    = {~key_q[10], ~rel_q, ext_q, shift_q};
                strobe_d = 1'b1;
                ext_d    = 1'b0;
                rel_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            wdog_q     <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            skip_q     <= '0;
            key_q      <= '0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_ok_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            data_s1_q  <= data_s1_d;
            data_s2_q  <= data_s2_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wdog_q     <= wdog_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            skip_q     <= skip_d;
            key_q      <= key_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            par_ok_q   <= par_ok_d;
`endif
        end
    end

    assign bus.ps2_key    = key_q;
    assign bus.key_strobe = strobe_q;
    assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_ps2_key_gen.sv
// Bench for ps2_key_gen: directed scancode sequences plus randomized frames checked
// against a byte-level key-event model.
module tb_ps2_key_gen;
    localparam int FILT = 8;
    localparam int TMO  = 1000;
    localparam int HALF = 20;

    logic clk;
    logic reset;
    ps2_key_gen_if bus();

    ps2_key_gen #(.CLK_FILTER(FILT), .TIMEOUT(TMO)) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int exp_strobes = 0;
    int exp_errs = 0;
    logic [10:0] prev_key = '0;

    logic [10:0] m_key;
    logic        m_ext, m_rel;
    int          m_skip;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Pulse counting and the rule that ps2_key changes exactly when key_strobe is high.
    always @(negedge clk) begin
        if (reset) begin
            prev_key = bus.ps2_key;
        end else begin
            if (bus.key_strobe) strobe_cnt++;
            if (bus.frame_err) err_cnt++;
            if (bus.key_strobe || (bus.ps2_key !== prev_key))
                checkOutput("strobe_vs_key", {31'b0, bus.key_strobe}, {31'b0, bus.ps2_key !== prev_key});
            prev_key = bus.ps2_key;
        end
    end

    task automatic modelReset();
        m_key = '0; m_ext = 1'b0; m_rel = 1'b0; m_skip = 0;
    endtask

    task automatic modelByte(input logic [7:0] b);
        if (m_skip > 0)        m_skip--;
        else if (b == 8'hE1)   m_skip = 7;
        else if (b == 8'hE0)   m_ext = 1'b1;
        else if (b == 8'hF0)   m_rel = 1'b1;
        else begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            exp_strobes++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic modelFrame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        bit good;
        good = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
        if (flip_par) good = 1'b0;
`endif
        if (good) modelByte(b);
        else begin
            exp_errs++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic sendBit(input logic v, input int glitch);
        bus.ps2_data = v;
        if (glitch > 0) begin
            repeat (HALF / 2) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (glitch) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (HALF - HALF / 2 - glitch) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                                 input int glitch, input int nbits);
        logic [10:0] frame;
        frame = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) sendBit(frame[i], (i == 3) ? glitch : 0);
        bus.ps2_data = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_key"}, {21'b0, bus.ps2_key}, {21'b0, m_key});
        checkOutput({tag, "_strobes"}, strobe_cnt, exp_strobes);
        checkOutput({tag, "_errs"}, err_cnt, exp_errs);
    endtask

    task automatic sendFrame(input string tag, input logic [7:0] b, input bit flip_par,
                             input bit bad_stop, input int glitch);
        applyStimulus(b, flip_par, bad_stop, glitch, 11);
        modelFrame(b, flip_par, bad_stop);
        checkState(tag);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        logic [7:0] rb;
        int r;
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        reset = 1'b1;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_key", {21'b0, bus.ps2_key}, 32'h0);
        checkOutput("rst_strobe", {31'b0, bus.key_strobe}, 32'h0);
        checkOutput("rst_err", {31'b0, bus.frame_err}, 32'h0);
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);

        sendFrame("f75", 8'h75, 1'b0, 1'b0, 0);
        checkOutput("f75_const", {21'b0, bus.ps2_key}, 32'h675);

        sendFrame("e0", 8'hE0, 1'b0, 1'b0, 0);
        sendFrame("f0", 8'hF0, 1'b0, 1'b0, 0);
        sendFrame("e0f075", 8'h75, 1'b0, 1'b0, 0);
        checkOutput("e0f075_const", {21'b0, bus.ps2_key}, 32'h175);

        sendFrame("par14", 8'h14, 1'b1, 1'b0, 0);

        // Partial frame after an E0 prefix: the timeout must not clear the prefix.
        sendFrame("pre_e0", 8'hE0, 1'b0, 1'b0, 0);
        applyStimulus(8'h2A, 1'b0, 1'b0, 0, 5);
        repeat (TMO + 10) @(negedge clk);
        exp_errs++;
        checkState("timeout");
        sendFrame("after_to", 8'h1C, 1'b0, 1'b0, 0);
        checkOutput("after_to_code", {24'b0, bus.ps2_key[7:0]}, 32'h1C);
        checkOutput("after_to_press", {31'b0, bus.ps2_key[9]}, 32'h1);

        foreach (pause_seq[i]) sendFrame("pause", pause_seq[i], 1'b0, 1'b0, 0);
        sendFrame("pause16", 8'h16, 1'b0, 1'b0, 0);
        checkOutput("pause16_const", {22'b0, bus.ps2_key[9:0]}, 32'h216);

        sendFrame("glitch_a", 8'h5A, 1'b0, 1'b0, FILT - 2);
        sendFrame("glitch_b", 8'hA5, 1'b0, 1'b0, 3);
        sendFrame("badstop", 8'h33, 1'b0, 1'b1, 0);

        // Reset in the middle of a frame, checked before any clock edge.
        for (int i = 0; i < 5; i++) sendBit((i == 0) ? 1'b0 : 1'(i & 1), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkOutput("midrst_key", {21'b0, bus.ps2_key}, 32'h0);
        checkOutput("midrst_strobe", {31'b0, bus.key_strobe}, 32'h0);
        checkOutput("midrst_err", {31'b0, bus.frame_err}, 32'h0);
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        repeat (3 * HALF) @(negedge clk);
        checkState("post_rst");
        sendFrame("post_rst_frame", 8'h29, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      rb = 8'hE0;
            else if (r == 1) rb = 8'hF0;
            else if (r == 2 && $urandom_range(0, 3) == 0) rb = 8'hE1;
            else             rb = 8'($urandom);
            sendFrame("rand", rb, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, FILT - 2) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
